// File: rtl/nco_multi.sv
// Multi-channel numerically controlled oscillator with per-channel sub-dividers
// and glitch-free, carry-aligned configuration updates through shadow registers.
module nco_multi #(
    parameter int N     = 32,
    parameter int CH    = 4,
    parameter int DIV_W = 8,
    parameter int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [N-1:0]     cfg_step,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_en,
    input  logic             sync,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    sub_tick
);

    logic [N-1:0]     r_phase   [CH];
    logic [N-1:0]     r_step    [CH];
    logic [DIV_W-1:0] r_div     [CH];
    logic [DIV_W-1:0] r_cnt     [CH];
    logic [CH-1:0]    r_en;

    logic [N-1:0]     r_sh_step [CH];
    logic [DIV_W-1:0] r_sh_div  [CH];
    logic [CH-1:0]    r_sh_en;
    logic [CH-1:0]    r_pending;

    logic [CH-1:0]    r_tick;
    logic [CH-1:0]    r_sub;

    logic [N:0]       w_sum     [CH];
    logic [CH-1:0]    w_commit;
    logic [CH-1:0]    w_accept;

    // A running channel normally commits only on its carry; a zero step (current
    // or newly requested with enable) would never carry, so it commits at once.
    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            w_sum[c]    = {1'b0, r_phase[c]} + {1'b0, r_step[c]};
            w_commit[c] = r_pending[c] &&
                          (w_sum[c][N] || (r_step[c] == '0) ||
                           ((r_sh_step[c] == '0) && r_sh_en[c]));
            w_accept[c] = cfg_valid && (cfg_ch == CH_W'(c)) && !r_pending[c];
        end
    end

    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned c = 0; c < CH; c++) begin
            if (cfg_ch == CH_W'(c)) cfg_ready = ~r_pending[c];
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            clk_out[c] = r_phase[c][N-1];
        end
    end

    assign tick     = r_tick;
    assign sub_tick = r_sub;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int unsigned c = 0; c < CH; c++) begin
                r_phase[c]   <= '0;
                r_step[c]    <= '0;
                r_div[c]     <= '0;
                r_cnt[c]     <= '0;
                r_sh_step[c] <= '0;
                r_sh_div[c]  <= '0;
            end
            r_en      <= '0;
            r_sh_en   <= '0;
            r_pending <= '0;
            r_tick    <= '0;
            r_sub     <= '0;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                if (sync) begin
                    r_phase[c] <= '0;
                    r_tick[c]  <= 1'b0;
                    r_sub[c]   <= 1'b0;
                    if (r_pending[c]) begin
                        r_step[c]    <= r_sh_step[c];
                        r_div[c]     <= r_sh_div[c];
                        r_en[c]      <= r_sh_en[c];
                        r_cnt[c]     <= r_sh_div[c];
                        r_pending[c] <= 1'b0;
                    end else begin
                        r_cnt[c] <= r_div[c];
                    end
                end else if (!r_en[c]) begin
                    r_phase[c] <= '0;
                    r_tick[c]  <= 1'b0;
                    r_sub[c]   <= 1'b0;
                    if (r_pending[c]) begin
                        r_step[c]    <= r_sh_step[c];
                        r_div[c]     <= r_sh_div[c];
                        r_en[c]      <= r_sh_en[c];
                        r_cnt[c]     <= r_sh_div[c];
                        r_pending[c] <= 1'b0;
                    end else begin
                        r_cnt[c] <= r_div[c];
                    end
                end else begin
                    r_phase[c] <= w_sum[c][N-1:0];
                    r_tick[c]  <= w_sum[c][N];
                    r_sub[c]   <= w_sum[c][N] && (r_cnt[c] == '0);
                    if (w_commit[c]) begin
                        r_step[c]    <= r_sh_step[c];
                        r_div[c]     <= r_sh_div[c];
                        r_en[c]      <= r_sh_en[c];
                        r_cnt[c]     <= r_sh_div[c];
                        r_pending[c] <= 1'b0;
                        if (!r_sh_en[c]) r_phase[c] <= '0;
                    end else if (w_sum[c][N]) begin
                        r_cnt[c] <= (r_cnt[c] == '0) ? r_div[c] : r_cnt[c] - 1'b1;
                    end
                end

                // Acceptance needs pending clear, so it never collides with a commit.
                if (w_accept[c]) begin
                    r_sh_step[c] <= cfg_step;
                    r_sh_div[c]  <= cfg_div;
                    r_sh_en[c]   <= cfg_en;
                    r_pending[c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nco_multi.sv
// Directed self-checking bench for nco_multi (N=8, CH=2, DIV_W=4, CH_W=2 so
// that an out-of-range channel number is representable).
module tb_nco_multi;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_step;
    logic [3:0] cfg_div;
    logic       cfg_en;
    logic       sync;
    logic [1:0] clk_out;
    logic [1:0] tick;
    logic [1:0] sub_tick;

    int n_checks = 0;
    int n_errors = 0;
    int k;
    logic [1:0] e_tick, e_sub, e_clk;

    nco_multi #(.N(8), .CH(2), .DIV_W(4), .CH_W(2)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_step  (cfg_step),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick),
        .sub_tick  (sub_tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [7:0] st,
                         input logic [3:0] dv, input logic en);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_step  = st;
        cfg_div   = dv;
        cfg_en    = en;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_step = '0;
        cfg_div = '0; cfg_en = 1'b0; sync = 1'b0;
        repeat (2) cyc();
        chk("rst_tick", tick, 2'b00);
        chk("rst_sub", sub_tick, 2'b00);
        chk("rst_clk", clk_out, 2'b00);
        chk("rst_ready", cfg_ready, 1'b1);
        rst = 1'b0;

        // ch0: step 64, div 2 from disabled -> commits on the edge after acceptance
        write(2'd0, 8'd64, 4'd2, 1'b1);
        cyc();
        chk("acc_pending", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        cyc();
        chk("commit_ready", cfg_ready, 1'b1);
        chk("commit_clk", clk_out, 2'b00);
        for (int j = 1; j <= 24; j++) begin
            cyc();
            chk("s64_tick", tick, {1'b0, (j % 4 == 0)});
            chk("s64_clk", clk_out, {1'b0, (j % 4 >= 2)});
            chk("s64_sub", sub_tick, {1'b0, (j % 12 == 0)});
        end

        // retune to step 128 mid-period: waits for the carry, no short pulse
        cyc();
        write(2'd0, 8'd128, 4'd0, 1'b1);
        cyc();
        chk("retune_pend0", cfg_ready, 1'b0);
        chk("retune_tick0", tick, 2'b00);
        cfg_valid = 1'b0;
        cyc();
        chk("retune_pend1", cfg_ready, 1'b0);
        chk("retune_tick1", tick, 2'b00);
        cyc();
        chk("retune_carry", tick, 2'b01);
        chk("retune_sub", sub_tick, 2'b00);
        chk("retune_ready", cfg_ready, 1'b1);
        for (int m = 1; m <= 8; m++) begin
            cyc();
            chk("s128_tick", tick, {1'b0, (m % 2 == 0)});
            chk("s128_sub", sub_tick, {1'b0, (m % 2 == 0)});
            chk("s128_clk", clk_out, {1'b0, (m % 2 == 1)});
        end

        // ch0 step 64 div 1, ch1 step 32 div 0, then sync
        write(2'd0, 8'd64, 4'd1, 1'b1);
        cyc();
        write(2'd1, 8'd32, 4'd0, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        repeat (4) cyc();
        cfg_ch = 2'd0; #1;
        chk("pre_sync_rdy0", cfg_ready, 1'b1);
        cfg_ch = 2'd1; #1;
        chk("pre_sync_rdy1", cfg_ready, 1'b1);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        k = 0;
        chk("sync_tick", tick, 2'b00);
        chk("sync_sub", sub_tick, 2'b00);
        chk("sync_clk", clk_out, 2'b00);
        for (int j = 1; j <= 16; j++) begin
            cyc();
            k++;
            e_tick = {(k % 8 == 0), (k % 4 == 0)};
            e_sub  = {(k % 8 == 0), (k % 8 == 0)};
            e_clk  = {(k % 8 >= 4), (k % 4 >= 2)};
            chk("sync_run_tick", tick, e_tick);
            chk("sync_run_sub", sub_tick, e_sub);
            chk("sync_run_clk", clk_out, e_clk);
        end

        // out-of-range channel: always ready, discarded
        write(2'd3, 8'd5, 4'd3, 1'b0);
        #1;
        chk("oor_ready", cfg_ready, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            cyc();
            k++;
            cfg_valid = 1'b0;
            e_tick = {(k % 8 == 0), (k % 4 == 0)};
            e_clk  = {(k % 8 >= 4), (k % 4 >= 2)};
            chk("oor_tick", tick, e_tick);
            chk("oor_clk", clk_out, e_clk);
        end
        cfg_ch = 2'd0; #1;
        chk("oor_rdy0", cfg_ready, 1'b1);
        cfg_ch = 2'd1; #1;
        chk("oor_rdy1", cfg_ready, 1'b1);

        // step 0 with enable on running ch1 commits immediately
        write(2'd1, 8'd0, 4'd0, 1'b1);
        cyc(); k++;
        chk("s0_pend", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        cyc(); k++;
        chk("s0_commit_rdy", cfg_ready, 1'b1);
        for (int j = 1; j <= 10; j++) begin
            cyc();
            k++;
            chk("s0_tick", tick, {1'b0, (k % 4 == 0)});
            chk("s0_sub", sub_tick, {1'b0, (k % 8 == 0)});
            chk("s0_clk", clk_out, {1'b0, (k % 4 >= 2)});
        end
        write(2'd1, 8'd0, 4'd0, 1'b0);
        #1;
        chk("dis_ready_pre", cfg_ready, 1'b1);
        cyc(); k++;
        chk("dis_pend", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        cyc(); k++;
        chk("dis_commit_rdy", cfg_ready, 1'b1);
        chk("dis_clk1", clk_out[1], 1'b0);

        // reset while ch1 has a pending write
        write(2'd1, 8'd16, 4'd0, 1'b1);
        cyc();
        chk("rst_pend", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_ready", cfg_ready, 1'b1);
        chk("rst2_tick", tick, 2'b00);
        chk("rst2_sub", sub_tick, 2'b00);
        chk("rst2_clk", clk_out, 2'b00);
        for (int j = 1; j <= 8; j++) begin
            cyc();
            chk("post_rst_tick", tick, 2'b00);
            chk("post_rst_clk", clk_out, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
